// File: rtl/ctrl_exec_unit.sv
// Execute stage behind the control-word ROM: IDLE -> EXEC -> WB FSM with an accumulator, a 4-entry register file and carry/zero flags.
// Define CTRL_EXEC_ILLEGAL_TRAP_EN to make illegal words halt the unit instead of acting as a NOP.
module ctrl_exec_unit #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        ctrl_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic              ctrl_valid,
    output logic              ctrl_ready,
    output logic [DATA_W-1:0] acc_out,
    output logic              carry_out,
    output logic              zero_out,
    output logic              done,
    output logic              illegal,
    output logic              halted
);
    // Handshake: a word transfers on a rising edge where ctrl_valid and ctrl_ready are both high;
    // ctrl_ready is high only in IDLE, and ctrl_in/imm_in are sampled at that edge only.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_started;
    logic [5:0]          r_ctrl;
    logic [DATA_W-1:0]   r_imm;
    logic [DATA_W-1:0]   r_acc;
    logic [DATA_W-1:0]   r_rf [4];
    logic                r_carry;
    logic                r_zero;
    logic                r_done;
    logic                r_illegal;
    logic                r_halted;

    logic [DATA_W-1:0]   r_res_acc;
    logic                r_res_carry;
    logic                r_res_zero;
    logic                r_res_rf_we;
    logic [1:0]          r_res_rf_idx;
    logic                r_res_halt;
    logic                r_res_ill;

    logic                w_sel_ok;
    logic [DATA_W-1:0]   w_opnd;
    logic [DATA_W:0]     w_sum;
    logic [DATA_W:0]     w_diff;
    logic [DATA_W-1:0]   w_acc;
    logic                w_carry;
    logic                w_zero;
    logic                w_rf_we;
    logic                w_halt;
    logic                w_ill;
    logic                w_accept;
    logic                w_trap;

`ifdef CTRL_EXEC_ILLEGAL_TRAP_EN
    assign w_trap = 1'b1;
`else
    assign w_trap = 1'b0;
`endif

    assign w_opnd = r_rf[r_ctrl[5:4]];
    assign w_sum  = {1'b0, r_acc} + {1'b0, w_opnd};
    assign w_diff = {1'b0, r_acc} - {1'b0, w_opnd};

    // Plain case on each field so unknown bits miss every item and land in the illegal default.
    always_comb begin
        w_sel_ok = 1'b0;
        w_acc    = r_acc;
        w_carry  = r_carry;
        w_zero   = r_zero;
        w_rf_we  = 1'b0;
        w_halt   = 1'b0;
        w_ill    = 1'b0;
        case (r_ctrl[5:4])
            2'b00, 2'b01, 2'b10, 2'b11: w_sel_ok = 1'b1;
            default:                    w_sel_ok = 1'b0;
        endcase
        if (!w_sel_ok) begin
            w_ill = 1'b1;
        end else begin
            case (r_ctrl[3:0])
                4'b0001: begin
                    w_acc   = w_sum[DATA_W-1:0];
                    w_carry = w_sum[DATA_W];
                    w_zero  = (w_sum[DATA_W-1:0] == '0);
                end
                4'b0011: begin
                    w_acc   = w_diff[DATA_W-1:0];
                    w_carry = w_diff[DATA_W];
                    w_zero  = (w_diff[DATA_W-1:0] == '0);
                end
                4'b0100: begin
                    w_acc   = '0;
                    w_carry = 1'b0;
                    w_zero  = 1'b1;
                end
                4'b1000: begin
                    w_acc  = r_imm;
                    w_zero = (r_imm == '0);
                end
                4'b1010: w_rf_we = 1'b1;
                4'b1011: begin
                    w_acc   = {r_acc[DATA_W-2:0], 1'b0};
                    w_carry = r_acc[DATA_W-1];
                    w_zero  = (r_acc[DATA_W-2:0] == '0);
                end
                4'b1111: w_halt = 1'b1;
                default: w_ill  = 1'b1;
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        ctrl_ready   = 1'b0;
        case (r_state)
            S_IDLE: begin
                ctrl_ready = r_started;
                if (r_started && ctrl_valid) w_next_state = S_EXEC;
            end
            S_EXEC: w_next_state = S_WB;
            S_WB:   w_next_state = (r_res_halt || (w_trap && r_res_ill)) ? S_HALT : S_IDLE;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_accept = ctrl_ready && ctrl_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started    <= 1'b0;
            r_ctrl       <= '0;
            r_imm        <= '0;
            r_acc        <= '0;
            for (int i = 0; i < 4; i++) r_rf[i] <= '0;
            r_carry      <= 1'b0;
            r_zero       <= 1'b0;
            r_done       <= 1'b0;
            r_illegal    <= 1'b0;
            r_halted     <= 1'b0;
            r_res_acc    <= '0;
            r_res_carry  <= 1'b0;
            r_res_zero   <= 1'b0;
            r_res_rf_we  <= 1'b0;
            r_res_rf_idx <= '0;
            r_res_halt   <= 1'b0;
            r_res_ill    <= 1'b0;
        end else begin
            r_started <= 1'b1;
            r_done    <= (r_state == S_WB);
            if (w_accept) begin
                r_ctrl <= ctrl_in;
                r_imm  <= imm_in;
            end
            if (r_state == S_EXEC) begin
                r_res_acc    <= w_acc;
                r_res_carry  <= w_carry;
                r_res_zero   <= w_zero;
                r_res_rf_we  <= w_rf_we;
                r_res_rf_idx <= r_imm[1:0];
                r_res_halt   <= w_halt;
                r_res_ill    <= w_ill;
            end
            // Everything architectural commits in WB only, so a reset in EXEC/WB leaves no trace.
            if (r_state == S_WB) begin
                r_acc   <= r_res_acc;
                r_carry <= r_res_carry;
                r_zero  <= r_res_zero;
                if (r_res_rf_we) r_rf[r_res_rf_idx] <= r_acc;
                if (r_res_ill) r_illegal <= 1'b1;
                if (r_res_halt || (w_trap && r_res_ill)) r_halted <= 1'b1;
            end
        end
    end

    assign acc_out   = r_acc;
    assign carry_out = r_carry;
    assign zero_out  = r_zero;
    assign done      = r_done;
    assign illegal   = r_illegal;
    assign halted    = r_halted;
endmodule

// File: tb/tb_ctrl_exec_unit.sv
// Bench for ctrl_exec_unit: directed cases plus random legal words against an arithmetic reference model.
module tb_ctrl_exec_unit;
    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    logic [5:0]   ctrl_in;
    logic [W-1:0] imm_in;
    logic         ctrl_valid;
    logic         ctrl_ready;
    logic [W-1:0] acc_out;
    logic         carry_out;
    logic         zero_out;
    logic         done;
    logic         illegal;
    logic         halted;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    int m_acc;
    int m_rf [4];
    bit m_c, m_z, m_ill, m_halt;

    ctrl_exec_unit #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_in    (ctrl_in),
        .imm_in     (imm_in),
        .ctrl_valid (ctrl_valid),
        .ctrl_ready (ctrl_ready),
        .acc_out    (acc_out),
        .carry_out  (carry_out),
        .zero_out   (zero_out),
        .done       (done),
        .illegal    (illegal),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0;
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_c = 0; m_z = 0; m_ill = 0; m_halt = 0;
    endfunction

    function automatic void model_apply(input logic [5:0] c, input logic [W-1:0] imm);
        int sel;
        int a;
        sel = int'(c[5:4]);
        case (c[3:0])
            4'h1: begin a = m_acc + m_rf[sel]; m_c = (a > MASK); m_acc = a & MASK; m_z = (m_acc == 0); end
            4'h3: begin m_c = (m_acc < m_rf[sel]); m_acc = (m_acc - m_rf[sel]) & MASK; m_z = (m_acc == 0); end
            4'h4: begin m_acc = 0; m_c = 0; m_z = 1; end
            4'h8: begin m_acc = int'(imm); m_z = (m_acc == 0); end
            4'hA: m_rf[int'(imm) % 4] = m_acc;
            4'hB: begin m_c = ((m_acc >> (W - 1)) & 1) != 0; m_acc = (m_acc * 2) & MASK; m_z = (m_acc == 0); end
            4'hF: m_halt = 1;
            default: begin
                m_ill = 1;
`ifdef CTRL_EXEC_ILLEGAL_TRAP_EN
                m_halt = 1;
`endif
            end
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, "_acc"},     32'(acc_out),   32'(m_acc));
        chk({tag, "_carry"},   32'(carry_out), 32'(m_c));
        chk({tag, "_zero"},    32'(zero_out),  32'(m_z));
        chk({tag, "_illegal"}, 32'(illegal),   32'(m_ill));
        chk({tag, "_halted"},  32'(halted),    32'(m_halt));
    endtask

    // Starts and ends just after a falling edge. hold=1 keeps ctrl_valid and the word on the bus.
    task automatic send(input logic [5:0] c, input logic [W-1:0] imm, input bit hold, output int waited);
        ctrl_in    = c;
        imm_in     = imm;
        ctrl_valid = 1'b1;
        waited     = 0;
        while (!ctrl_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!ctrl_ready) begin
            chk("accept_timeout", 32'(ctrl_ready), 32'd1);
            ctrl_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_apply(c, imm);
        @(negedge clk);
        if (!hold) begin
            ctrl_valid = 1'b0;
            ctrl_in    = 6'($urandom);
            imm_in     = W'($urandom);
        end
        chk("exec_ready", 32'(ctrl_ready), 32'd0);
        chk("exec_done",  32'(done),       32'd0);
        @(negedge clk);
        chk("wb_ready", 32'(ctrl_ready), 32'd0);
        chk("wb_done",  32'(done),       32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done),       32'd1);
        chk("ready_back", 32'(ctrl_ready), 32'(!m_halt));
        check_outputs("commit");
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        ctrl_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ctrl_ready), 32'd0);
        chk("rst_done",  32'(done),       32'd0);
        check_outputs("rst");
        rst_n = 1'b1;
        #1;
        chk("rel_ready_low", 32'(ctrl_ready), 32'd0);
        @(negedge clk);
        chk("rel_ready_high", 32'(ctrl_ready), 32'd1);
    endtask

    initial begin : main
        int w;
        logic [3:0] ops [6];
        logic [3:0] op;
        logic [1:0] sel;
        ops[0] = 4'h1; ops[1] = 4'h3; ops[2] = 4'h4;
        ops[3] = 4'h8; ops[4] = 4'hA; ops[5] = 4'hB;
        ctrl_in = '0;
        imm_in  = '0;
        ctrl_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        do_reset();

        send(6'b00_1000, 8'h7F, 0, w);
        send(6'b00_1010, 8'h01, 0, w);
        // ADD carry-out to zero: acc=FF + R1=01
        send(6'b00_1000, 8'h01, 0, w);
        send(6'b00_1010, 8'h01, 0, w);
        send(6'b00_1000, 8'hFF, 0, w);
        send(6'b01_0001, 8'h00, 0, w);
        // SUB borrow: acc=05 - R2=07
        send(6'b00_1000, 8'h07, 0, w);
        send(6'b00_1010, 8'h02, 0, w);
        send(6'b00_1000, 8'h05, 0, w);
        send(6'b10_0011, 8'h00, 0, w);

        // valid held high across four queued words
        send(6'b00_1000, 8'h03, 1, w);
        send(6'b00_1011, 8'h00, 1, w);
        chk("b2b_wait1", 32'(w), 32'd0);
        send(6'b10_0001, 8'h00, 1, w);
        chk("b2b_wait2", 32'(w), 32'd0);
        send(6'b01_0011, 8'h00, 1, w);
        chk("b2b_wait3", 32'(w), 32'd0);
        ctrl_valid = 1'b0;

        for (int i = 0; i < 40; i++) begin
            op  = ops[$urandom_range(5)];
            sel = (op == 4'h1 || op == 4'h3) ? 2'($urandom_range(3)) : 2'b00;
            send({sel, op}, W'($urandom_range(MASK)), 0, w);
        end

        send(6'b00_1000, 8'h5A, 0, w);
        send(6'b00_0010, 8'h00, 0, w);
`ifdef CTRL_EXEC_ILLEGAL_TRAP_EN
        repeat (3) @(negedge clk);
        chk("trap_ready_stays_low", 32'(ctrl_ready), 32'd0);
        do_reset();
`else
        send(6'b11_0111, 8'h00, 0, w);
        send(6'b00_1000, 8'h21, 0, w);
`endif

        send(6'b00_1000, 8'h33, 0, w);
        send(6'b00_1111, 8'h00, 0, w);
        ctrl_valid = 1'b1;
        ctrl_in    = 6'b00_1000;
        repeat (4) @(negedge clk);
        chk("halt_ready_low", 32'(ctrl_ready), 32'd0);
        check_outputs("halt_hold");
        do_reset();

        // reset in the middle of EXEC aborts an ADD
        send(6'b00_1000, 8'h44, 0, w);
        ctrl_in    = 6'b01_0001;
        ctrl_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ctrl_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_done", 32'(done), 32'd0);
        check_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ctrl_ready), 32'd1);
        chk("abort_no_done", 32'(done), 32'd0);
        check_outputs("after_abort");
        send(6'b00_1000, 8'h11, 0, w);
        send(6'b01_0001, 8'h00, 0, w);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/ctrl_exec_unit.md
# ctrl_exec_unit

Execute stage that sits directly downstream of the 6-bit control-word ROM. Accepts one control word per transaction over a valid/ready handshake, decodes the opcode field and target-register field, and runs a small multi-cycle FSM. The FSM updates an accumulator, a 4-entry register file and carry/zero flags. It reports completion with a one-cycle done pulse and stops permanently on HALT.

## Interface
Parameters:
- DATA_W, 8, width of accumulator, register file entries and imm_in

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_in  in  6  control word from ROM: [5:4] register select, [3:0] opcode
- imm_in  in  DATA_W  immediate operand, sampled with ctrl_in
- ctrl_valid  in  1  ctrl_in/imm_in valid
- ctrl_ready  out  1  unit can accept a word
- acc_out  out  DATA_W  accumulator
- carry_out  out  1  carry/borrow flag
- zero_out  out  1  zero flag
- done  out  1  one-cycle pulse per completed word
- illegal  out  1  sticky: an unrecognised word was accepted
- halted  out  1  sticky: HALT executed

## Operation
- Opcodes (ctrl_in[3:0]), sel = ctrl_in[5:4]:
  - 0001 ADD: acc = acc + R[sel]; carry = bit DATA_W of the sum.
  - 0011 SUB: acc = acc - R[sel]; carry = borrow (1 when acc < R[sel], unsigned).
  - 0100 CLR: acc = 0; carry = 0.
  - 1000 LDI: acc = imm.
  - 1010 STR: R[imm[1:0]] = acc.
  - 1011 SHL: acc = acc << 1; carry = old acc[DATA_W-1].
  - 1111 HALT.
- The ROM only emits sel != 00 for ADD/SUB. sel is ignored for all other opcodes.
- Zero flag = (new acc == 0). It is updated by ADD, SUB, CLR, SHL and LDI. STR, HALT and illegal words leave both flags unchanged. LDI leaves carry unchanged.
- Any other opcode, and any word containing X/Z (the ROM drives Z for undefined inputs), falls into the decoder default and is illegal.
- FSM states: IDLE, EXEC, WB, HALT.
  - IDLE: ctrl_ready=1. On ctrl_valid, latch ctrl_in and imm_in, then go to EXEC.
  - EXEC: compute the result and the next flags into internal registers, then go to WB.
  - WB: commit acc/R/flags and pulse done. For HALT, set halted and go to HALT. Otherwise go to IDLE.
  - HALT: ctrl_ready=0 forever; only reset exits.
- Reset values: acc_out=0, R0..R3=0, carry_out=0, zero_out=0, done=0, illegal=0, halted=0, ctrl_ready=0 while rst_n low, state=IDLE.

## Timing
- The word is accepted at rising edge k, when ctrl_valid=1 and ctrl_ready=1.
- EXEC occupies cycle k..k+1. WB commits at edge k+2.
- done is high for exactly the cycle after edge k+2. Results are visible on acc_out and the flags in that same cycle.
- ctrl_ready returns high in that same cycle. The next word can be accepted at edge k+3, giving a maximum throughput of 1 word per 3 cycles.
- ctrl_ready is low in EXEC and WB. ctrl_valid in those states is ignored; the upstream stage must hold its word.
- ctrl_in and imm_in are sampled only at the accept edge. Later changes have no effect.
- Back-to-back dependency: the second word sees the committed acc of the first word. No bypass is needed.
- STR to a register followed by ADD of the same register uses the stored value.
- Reset asserted in EXEC or WB aborts the transaction. Nothing commits, done stays 0, and all outputs go to their reset values immediately (asynchronous).
- ctrl_ready rises in the first cycle after the first clock edge following rst_n release.

## Configuration
- CTRL_EXEC_ILLEGAL_TRAP_EN defined:
  - An illegal word sets illegal.
  - It enters HALT at WB with halted=1 and pulses done.
- Not defined:
  - An illegal word is a NOP: no state change, done pulses, illegal is still set (sticky), FSM returns to IDLE.

## Test plan
- Reset, then LDI imm=0x7F, then STR imm=01 → acc_out=0x7F, R1=0x7F, zero=0; done pulses 3 cycles after each accept.
- ADD with acc=0xFF, R1=0x01 (ctrl_in=6'b01_0001) → acc_out=0x00, carry=1, zero=1.
- SUB with acc=0x05, R2=0x07 (ctrl_in=6'b10_0011) → acc_out=0xFE, carry=1, zero=0.
- ctrl_valid held high with 4 queued words → exactly one accept every 3 cycles; ctrl_ready low in EXEC/WB; 4 done pulses.
- ctrl_in=6'bzzzzzz (or 6'b000010) → illegal=1.
  - With CTRL_EXEC_ILLEGAL_TRAP_EN: halted=1 and ctrl_ready stays 0.
  - Without it: acc is unchanged and the next word is accepted.
- HALT (6'b00_1111), then rst_n pulsed low mid-EXEC of a later ADD → halted=0, acc_out=0, no done pulse, ctrl_ready=1 after release.
